vproc_cfg_unit: RTL and testbench

// - Executes vsetvl/vsetvli/vsetivli and holds the architectural vtype/vl state.
// - Parametrised in VLEN, XLEN and maximum LMUL. Adds vill detection, SEW/LMUL-ratio

---
 rtl/vproc_pkg.sv | 52 +++++
 rtl/vproc_cfg_unit_if.sv | 25 ++
 rtl/vproc_cfg_vlcalc.sv | 48 ++++
 rtl/vproc_cfg_unit.sv | 112 +++++++++++
 tb/tb_vproc_cfg_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/vproc_pkg.sv
// Shared vector-config types and the VLMAX helper used by the config unit and the decoder.
package vproc_pkg;

  typedef enum logic [1:0] {
    VSEW_8       = 2'b00,
    VSEW_16      = 2'b01,
    VSEW_32      = 2'b10,
    VSEW_INVALID = 2'b11
  } cfg_vsew;

  // bit 2 set marks fractional LMUL; 3'b100 is reserved
  typedef enum logic [2:0] {
    LMUL_1       = 3'b000,
    LMUL_2       = 3'b001,
    LMUL_4       = 3'b010,
    LMUL_8       = 3'b011,
    LMUL_INVALID = 3'b100,
    LMUL_F8      = 3'b101,
    LMUL_F4      = 3'b110,
    LMUL_F2      = 3'b111
  } cfg_lmul;

  typedef enum logic [1:0] {
    EVL_DEFAULT = 2'b00,
    EVL_1       = 2'b01,
    EVL_MASK    = 2'b10,
    EVL_MAX     = 2'b11
  } evl_policy;

  typedef struct packed {
    cfg_vsew    vsew;
    cfg_lmul    lmul;
    logic [1:0] agnostic;
    logic       vlmax;
    logic       keep_vl;
  } op_mode_cfg;

  typedef enum logic [1:0] {
    CFG_IDLE = 2'b00,
    CFG_CALC = 2'b01,
    CFG_RESP = 2'b10
  } cfg_fsm;

  function automatic int unsigned cfg_vlmax(cfg_vsew vsew, cfg_lmul lmul, int unsigned vreg_w);
    int unsigned base;
    base = (vreg_w / 8) >> vsew;
    if (vsew == VSEW_INVALID || lmul == LMUL_INVALID) return 0;
    if (lmul[2]) return base >> (4'd8 - {1'b0, lmul});
    return base << lmul[1:0];
  endfunction

endpackage

// File: rtl/vproc_cfg_unit_if.sv
// Config-op request and vl write-back handshakes between decoder and config unit.
interface vproc_cfg_unit_if #(
  parameter int unsigned XLEN = 32
) ();
  import vproc_pkg::*;

  logic             op_valid;
  logic             op_ready;
  op_mode_cfg       op_mode;
  logic [XLEN-1:0]  op_avl;
  logic             op_rd_en;
  logic             rd_valid;
  logic             rd_ready;
  logic [XLEN-1:0]  rd_data;

  modport master (
    output op_valid, op_mode, op_avl, op_rd_en, rd_ready,
    input  op_ready, rd_valid, rd_data
  );

  modport slave (
    input  op_valid, op_mode, op_avl, op_rd_en, rd_ready,
    output op_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/vproc_cfg_vlcalc.sv
// Combinational vtype legality check and new-vl computation for one config op.
module vproc_cfg_vlcalc import vproc_pkg::*; #(
  parameter int unsigned VREG_W   = 128,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned LMUL_MAX = 8,
  parameter int unsigned ELEN     = 32,
  parameter int unsigned VL_W     = $clog2(VREG_W) + 1
) (
  input  cfg_vsew          vsew,
  input  cfg_lmul          lmul,
  input  logic             vlmax_flag,
  input  logic             keep_vl,
  input  logic [XLEN-1:0]  avl,
  input  cfg_vsew          cur_vsew,
  input  cfg_lmul          cur_lmul,
  input  logic             cur_vill,
  input  logic [VL_W-1:0]  cur_vl,
  output logic             vill,
  output logic [VL_W-1:0]  vl
);
  int unsigned     vlmax_new;
  int unsigned     vlmax_cur;
  int unsigned     sew_bits;
  logic [XLEN-1:0] vlmax_x;

  always_comb begin
    vlmax_new = cfg_vlmax(vsew, lmul, VREG_W);
    vlmax_cur = cfg_vlmax(cur_vsew, cur_lmul, VREG_W);
    sew_bits  = 32'd8 << vsew;
    vlmax_x   = XLEN'(vlmax_new);
    vill      = 1'b0;
    if (vsew == VSEW_INVALID || lmul == LMUL_INVALID)
      vill = 1'b1;
    else if (!lmul[2] && (32'd1 << lmul[1:0]) > LMUL_MAX)
      vill = 1'b1;
    else if (lmul[2] && (sew_bits << (4'd8 - {1'b0, lmul})) > ELEN)
      vill = 1'b1;
    // legal configs never truncate VLMAX, so equal VLMAX <=> equal SEW/LMUL ratio
    if (keep_vl && (cur_vill || vlmax_new != vlmax_cur))
      vill = 1'b1;
    vl = '0;
    if (!vill) begin
      if (keep_vl)                          vl = cur_vl;
      else if (vlmax_flag || avl >= vlmax_x) vl = VL_W'(vlmax_new);
      else                                  vl = avl[VL_W-1:0];
    end
  end
endmodule

// File: rtl/vproc_cfg_unit.sv
// vset{i}vl{i} execution: holds architectural vtype/vl and serves per-policy EVL.
module vproc_cfg_unit import vproc_pkg::*; #(
  parameter int unsigned VREG_W   = 128,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned LMUL_MAX = 8,
  parameter int unsigned ELEN     = 32,
  parameter int unsigned VL_W     = $clog2(VREG_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  vproc_cfg_unit_if.slave   bus,
  output logic              busy,
  output cfg_vsew           vsew,
  output cfg_lmul           lmul,
  output logic [1:0]        agnostic,
  output logic              vill,
  output logic [VL_W-1:0]   vl,
  input  evl_policy         evl_pol,
  output logic [VL_W-1:0]   evl
);
  cfg_fsm          state, next_state;
  op_mode_cfg      op_q;
  logic [XLEN-1:0] avl_q;
  logic            rd_en_q;
  logic            calc_vill;
  logic [VL_W-1:0] calc_vl;

  vproc_cfg_vlcalc #(
    .VREG_W(VREG_W), .XLEN(XLEN), .LMUL_MAX(LMUL_MAX), .ELEN(ELEN), .VL_W(VL_W)
  ) u_vlcalc (
    .vsew       (op_q.vsew),
    .lmul       (op_q.lmul),
    .vlmax_flag (op_q.vlmax),
    .keep_vl    (op_q.keep_vl),
    .avl        (avl_q),
    .cur_vsew   (vsew),
    .cur_lmul   (lmul),
    .cur_vill   (vill),
    .cur_vl     (vl),
    .vill       (calc_vill),
    .vl         (calc_vl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CFG_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state   = state;
    bus.op_ready = 1'b0;
    bus.rd_valid = 1'b0;
    busy         = 1'b0;
    case (state)
      CFG_IDLE: begin
        bus.op_ready = 1'b1;
        if (bus.op_valid) next_state = CFG_CALC;
      end
      CFG_CALC: begin
        busy       = 1'b1;
        next_state = rd_en_q ? CFG_RESP : CFG_IDLE;
      end
      CFG_RESP: begin
        bus.rd_valid = 1'b1;
        if (bus.rd_ready) next_state = CFG_IDLE;
      end
      default: next_state = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      avl_q       <= '0;
      rd_en_q     <= 1'b0;
      vsew        <= VSEW_8;
      lmul        <= LMUL_1;
      agnostic    <= 2'b00;
      vill        <= 1'b1;
      vl          <= '0;
      bus.rd_data <= '0;
    end else begin
      if (state == CFG_IDLE && bus.op_valid) begin
        op_q    <= bus.op_mode;
        avl_q   <= bus.op_avl;
        rd_en_q <= bus.op_rd_en;
      end
      // requested encodings are kept even when illegal; vl is forced to 0 by vlcalc
      if (state == CFG_CALC) begin
        vsew     <= op_q.vsew;
        lmul     <= op_q.lmul;
        agnostic <= op_q.agnostic;
        vill     <= calc_vill;
        vl       <= calc_vl;
        if (rd_en_q) bus.rd_data <= XLEN'(calc_vl);
      end
    end
  end

  always_comb begin
    evl = '0;
    if (!vill) begin
      case (evl_pol)
        EVL_DEFAULT: evl = vl;
        EVL_1:       evl = VL_W'(1);
        EVL_MASK:    evl = (vl + VL_W'(7)) >> 3;
        EVL_MAX:     evl = VL_W'(cfg_vlmax(vsew, lmul, VREG_W));
        default:     evl = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_vproc_cfg_unit.sv
// Directed bench for vproc_cfg_unit with a write-back scoreboard queue.
module tb_vproc_cfg_unit;
  import vproc_pkg::*;

  localparam int VL_W = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            busy, vill;
  cfg_vsew         vsew;
  cfg_lmul         lmul;
  logic [1:0]      agnostic;
  logic [VL_W-1:0] vl, evl;
  evl_policy       evl_pol;

  int              errors = 0;
  int              checks = 0;
  logic [31:0]     sbq[$];

  vproc_cfg_unit_if #(.XLEN(32)) bus ();

  vproc_cfg_unit #(
    .VREG_W(128), .XLEN(32), .LMUL_MAX(8), .ELEN(32), .VL_W(VL_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .vsew     (vsew),
    .lmul     (lmul),
    .agnostic (agnostic),
    .vill     (vill),
    .vl       (vl),
    .evl_pol  (evl_pol),
    .evl      (evl)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop(string tag);
    if (sbq.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    else                 chk({tag, "_rd_data"}, bus.rd_data, sbq.pop_front());
  endtask

  task automatic drive(cfg_vsew s, cfg_lmul l, logic vmax, logic keep,
                       logic [31:0] avl, logic rd_en);
    bus.op_valid = 1'b1;
    bus.op_mode  = '{vsew: s, lmul: l, agnostic: 2'b01, vlmax: vmax, keep_vl: keep};
    bus.op_avl   = avl;
    bus.op_rd_en = rd_en;
  endtask

  // full transaction: accept, CALC, result visible two cycles after accept
  task automatic run_op(string tag, cfg_vsew s, cfg_lmul l, logic vmax, logic keep,
                        logic [31:0] avl, logic rd_en, logic [7:0] exp_vl, logic exp_vill);
    drive(s, l, vmax, keep, avl, rd_en);
    if (rd_en) sbq.push_back({24'd0, exp_vl});
    step();
    bus.op_valid = 1'b0;
    chk({tag, "_calc_busy"}, busy, 1);
    chk({tag, "_calc_ready"}, bus.op_ready, 0);
    chk({tag, "_calc_rdv"}, bus.rd_valid, 0);
    step();
    chk({tag, "_vl"}, vl, exp_vl);
    chk({tag, "_vill"}, vill, exp_vill);
    chk({tag, "_rdv"}, bus.rd_valid, rd_en);
    if (rd_en) begin
      chk({tag, "_resp_busy"}, busy, 0);
      sb_pop(tag);
      bus.rd_ready = 1'b1;
      step();
      bus.rd_ready = 1'b0;
    end
    chk({tag, "_idle_ready"}, bus.op_ready, 1);
  endtask

  task automatic chk_evl(string tag, logic [7:0] e_def, logic [7:0] e_one,
                         logic [7:0] e_mask, logic [7:0] e_max);
    evl_pol = EVL_DEFAULT; #1; chk({tag, "_evl_def"},  evl, e_def);
    evl_pol = EVL_1;       #1; chk({tag, "_evl_1"},    evl, e_one);
    evl_pol = EVL_MASK;    #1; chk({tag, "_evl_mask"}, evl, e_mask);
    evl_pol = EVL_MAX;     #1; chk({tag, "_evl_max"},  evl, e_max);
    evl_pol = EVL_DEFAULT;
  endtask

  initial begin
    bus.op_valid = 1'b0;
    bus.op_mode  = '0;
    bus.op_avl   = '0;
    bus.op_rd_en = 1'b0;
    bus.rd_ready = 1'b0;
    evl_pol      = EVL_DEFAULT;
    rst_n        = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    chk("rst_vill", vill, 1);
    chk("rst_vl", vl, 0);
    chk("rst_ready", bus.op_ready, 1);
    chk("rst_rdv", bus.rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_vsew", vsew, VSEW_8);
    chk("rst_lmul", lmul, LMUL_1);
    chk_evl("rst", 0, 0, 0, 0);

    run_op("e32m4", VSEW_32, LMUL_4, 0, 0, 100, 1, 16, 0);
    run_op("e8mf2", VSEW_8, LMUL_F2, 0, 0, 5, 0, 5, 0);
    chk_evl("e8mf2", 5, 1, 1, 8);

    run_op("e8m1", VSEW_8, LMUL_1, 0, 0, 7, 1, 7, 0);
    run_op("keep_e16m2", VSEW_16, LMUL_2, 0, 1, 99, 1, 7, 0);
    run_op("keep_e32m1", VSEW_32, LMUL_1, 0, 1, 99, 1, 0, 1);
    chk_evl("vill", 0, 0, 0, 0);
    run_op("keep_on_vill", VSEW_32, LMUL_1, 0, 1, 9, 0, 0, 1);
    run_op("e32mf8", VSEW_32, LMUL_F8, 0, 0, 3, 1, 0, 1);

    // write-back backpressure with a second op offered during RESP
    drive(VSEW_16, LMUL_1, 0, 0, 50, 1);
    sbq.push_back(32'd8);
    step();
    bus.op_valid = 1'b0;
    step();
    chk("bp_rdv", bus.rd_valid, 1);
    chk("bp_busy", busy, 0);
    drive(VSEW_8, LMUL_2, 0, 0, 20, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_rdv", bus.rd_valid, 1);
      chk("bp_hold_data", bus.rd_data, 8);
      chk("bp_hold_ready", bus.op_ready, 0);
      chk("bp_hold_busy", busy, 0);
    end
    sb_pop("bp");
    bus.rd_ready = 1'b1;
    step();
    bus.rd_ready = 1'b0;
    chk("bp_after_rdv", bus.rd_valid, 0);
    chk("bp_after_ready", bus.op_ready, 1);
    chk("bp_after_busy", busy, 0);
    step();
    bus.op_valid = 1'b0;
    chk("bp_op2_busy", busy, 1);
    step();
    chk("bp_op2_vl", vl, 20);
    chk("bp_op2_rdv", bus.rd_valid, 0);

    run_op("vlmax_e16m8", VSEW_16, LMUL_8, 1, 0, 0, 1, 64, 0);
    run_op("avl256_e8m8", VSEW_8, LMUL_8, 0, 0, 256, 1, 128, 0);
    run_op("avlmax_e8m1", VSEW_8, LMUL_1, 0, 0, 32'hFFFF_FFFF, 0, 16, 0);
    run_op("avl0_e8m1", VSEW_8, LMUL_1, 0, 0, 0, 0, 0, 0);
    run_op("e32mf2", VSEW_32, LMUL_F2, 0, 0, 4, 0, 0, 1);
    run_op("e16mf2", VSEW_16, LMUL_F2, 0, 0, 10, 1, 4, 0);
    chk_evl("e16mf2", 4, 1, 1, 4);
    run_op("sew_inv", VSEW_INVALID, LMUL_1, 0, 0, 5, 1, 0, 1);
    chk("sew_inv_vsew", vsew, VSEW_INVALID);
    run_op("lmul_inv", VSEW_8, LMUL_INVALID, 0, 0, 5, 0, 0, 1);

    // reset pulse while CALC is in progress
    run_op("pre_rst", VSEW_8, LMUL_1, 0, 0, 9, 0, 9, 0);
    drive(VSEW_8, LMUL_2, 0, 0, 3, 1);
    step();
    bus.op_valid = 1'b0;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_vill", vill, 1);
    chk("mid_rst_vl", vl, 0);
    chk("mid_rst_rdv", bus.rd_valid, 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_rdv", bus.rd_valid, 0);
    chk("post_rst_vl", vl, 0);
    chk("post_rst_ready", bus.op_ready, 1);
    chk("sb_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
